nios2_dbg_slave_sysclk_cmdq: RTL and testbench

// - Sysclk-side half of the next-generation Nios II JTAG debug slave; successor to the fixed 38-bit/2-bit-IR sysclk capture.
// - Synchronises the virtual-JTAG update strobes (vs_uir/vs_udr) into clk, latches IR and the TCK-domain shift register.
// - Queues each update as a command in a DEPTH-entry FIFO with a valid/ready handshake instead of single-cycle take_action pulses.
// - Also decodes per-IR take_action/take_no_action pulses at pop time for the existing OCI consumers.

---
 rtl/nios2_dbg_pkg.sv | 19 +
 rtl/nios2_dbg_sync_edge.sv | 39 +++
 rtl/nios2_dbg_slave_sysclk_cmdq.sv | 141 ++++++++++++++
 tb/tb_nios2_dbg_slave_sysclk_cmdq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug slave, sysclk side.
// Virtual IR codes, default widths and the queued command bundle.
package nios2_dbg_pkg;

    localparam int DBG_SR_W    = 38;
    localparam int DBG_IR_W    = 2;
    localparam int DBG_ACT_BIT = 35;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_SR_W-1:0] jdo;
    } dbg_cmd_t;

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Strobe synchroniser with rising-edge detect.
// Rises are ignored until the synced level has been seen low once after reset.
module nios2_dbg_sync_edge
    import nios2_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] filled;
    logic                   sync_d;
    logic                   armed;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];
    assign rise     = armed & sync_out & ~sync_d;

    // Synchroniser chain, fill tracker, edge flop and arm flag.
    // The fill tracker keeps the reset-forced zeros from counting as a real low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            filled <= '0;
            sync_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], async_in};
            filled <= {filled[SYNC_STAGES-2:0], 1'b1};
            sync_d <= sync_out;
            armed  <= armed | (filled[SYNC_STAGES-1] & ~sync_out);
        end
    end

endmodule

// File: rtl/nios2_dbg_slave_sysclk_cmdq.sv
// Sysclk half of the JTAG debug slave: synchronised IR/DR updates
// are queued as commands and decoded into per-IR pulses on pop.
module nios2_dbg_slave_sysclk_cmdq
    import nios2_dbg_pkg::*;
#(
    parameter int SR_W        = DBG_SR_W,
    parameter int IR_W        = DBG_IR_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = DBG_ACT_BIT,
    localparam int NUM_IR     = 2 ** IR_W,
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   cmd_jdo,
    output logic [NUM_IR-1:0] take_action,
    output logic [NUM_IR-1:0] take_no_action,
    output logic [IR_W-1:0]   ir_q,
    output logic [PW:0]       fifo_count,
    output logic              overflow,
    input  logic              overflow_clr
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] jdo;
    } cmd_t;

    localparam logic [NUM_IR-1:0] ONE_HOT0 = NUM_IR'(1);
    localparam logic [PW:0]       FULL_CNT = (PW+1)'(DEPTH);

    logic        uir_rise;
    logic        udr_rise;
    cmd_t        mem [DEPTH];
    cmd_t        head;
    cmd_t        wdata;
    logic [PW:0] wr_cnt;
    logic [PW:0] rd_cnt;
    logic        full;
    logic        pop;
    logic        do_push;
    logic        drop;

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_uir (
        .clk     (clk),
        .reset   (reset),
        .async_in(vs_uir),
        .rise    (uir_rise)
    );

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_udr (
        .clk     (clk),
        .reset   (reset),
        .async_in(vs_udr),
        .rise    (udr_rise)
    );

    assign fifo_count = wr_cnt - rd_cnt;
    assign full       = (fifo_count == FULL_CNT);
    assign cmd_valid  = (fifo_count != '0);
    assign pop        = cmd_valid & cmd_ready;
    assign do_push    = udr_rise & (~full | pop);
    assign drop       = udr_rise & full & ~pop;
    assign wdata      = '{ir: ir_q, jdo: sr};
    assign head       = cmd_valid ? mem[rd_cnt[PW-1:0]] : '0;
    assign cmd_ir     = head.ir;
    assign cmd_jdo    = head.jdo;

    // Latch the virtual IR on each synchronised update-IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
        end else if (uir_rise) begin
            ir_q <= ir_in;
        end
    end

    // Command storage; contents are masked at the output when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_cnt[PW-1:0]] <= wdata;
        end
    end

    // Pointers with an extra wrap bit so occupancy is a plain difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Sticky drop flag; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // One-cycle per-IR pulse for the popped command.
    always_ff @(posedge clk) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (head.jdo[ACT_BIT]) begin
                    take_action <= ONE_HOT0 << head.ir;
                end else begin
                    take_no_action <= ONE_HOT0 << head.ir;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_dbg_slave_sysclk_cmdq.sv
// Directed bench for the debug command queue.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_nios2_dbg_slave_sysclk_cmdq;

    import nios2_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir;
    logic        vs_udr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [1:0]  ir_q;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        overflow_clr;

    int checks   = 0;
    int failures = 0;

    logic [37:0] d [5];

    nios2_dbg_slave_sysclk_cmdq dut (
        .clk           (clk),
        .reset         (reset),
        .ir_in         (ir_in),
        .sr            (sr),
        .vs_uir        (vs_uir),
        .vs_udr        (vs_udr),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_ir        (cmd_ir),
        .cmd_jdo       (cmd_jdo),
        .take_action   (take_action),
        .take_no_action(take_no_action),
        .ir_q          (ir_q),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One update-DR: high one cycle, low two; push lands on the third edge.
    task automatic udr_pulse(input logic [37:0] data);
        sr     = data;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick(2);
    endtask

    task automatic uir_pulse(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick();
        vs_uir = 1'b0;
        tick(2);
    endtask

    initial begin
        reset        = 1'b1;
        ir_in        = '0;
        sr           = '0;
        vs_uir       = 1'b0;
        vs_udr       = 1'b0;
        cmd_ready    = 1'b0;
        overflow_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d[i] = 38'h0100000000 + 38'(i * 38'h11);
        end

        tick(2);
        reset = 1'b0;
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_irq", 64'(ir_q), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_act", 64'({take_action, take_no_action}), 64'd0);
        check("rst_jdo", 64'(cmd_jdo), 64'd0);
        tick(5);

        ir_in  = IR_BREAK;
        vs_uir = 1'b1;
        tick();
        vs_uir = 1'b0;
        tick();
        check("irq_early", 64'(ir_q), 64'd0);
        tick();
        check("irq_lat3", 64'(ir_q), 64'd2);

        sr     = 38'h0812345678;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        check("valid_early", 64'(cmd_valid), 64'd0);
        tick();
        check("valid_lat3", 64'(cmd_valid), 64'd1);
        check("head_ir", 64'(cmd_ir), 64'd2);
        check("head_jdo", 64'(cmd_jdo), 64'h0812345678);
        check("count1", 64'(fifo_count), 64'd1);
        tick(2);
        check("hold_jdo", 64'(cmd_jdo), 64'h0812345678);
        check("no_pulse", 64'(take_action), 64'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("act_pulse", 64'(take_action), 64'h4);
        check("noact_zero", 64'(take_no_action), 64'd0);
        check("count0", 64'(fifo_count), 64'd0);
        tick();
        check("act_clear", 64'(take_action), 64'd0);

        uir_pulse(IR_OCIMEM);
        check("irq_0", 64'(ir_q), 64'd0);
        cmd_ready = 1'b1;
        udr_pulse(38'h00000000AB);
        check("v2_valid", 64'(cmd_valid), 64'd1);
        check("v2_jdo", 64'(cmd_jdo), 64'hAB);
        tick();
        check("noact_pulse", 64'(take_no_action), 64'h1);
        check("act_zero", 64'(take_action), 64'd0);
        check("v2_count0", 64'(fifo_count), 64'd0);
        tick();
        check("noact_clear", 64'(take_no_action), 64'd0);
        cmd_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            udr_pulse(d[i]);
        end
        check("full_count", 64'(fifo_count), 64'd4);
        check("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 64'(cmd_jdo), 64'(d[i]));
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        check("drain_count", 64'(fifo_count), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        for (int i = 0; i < 4; i++) begin
            udr_pulse(d[i]);
        end
        check("refill", 64'(fifo_count), 64'd4);
        sr     = 38'h00000000EE;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pp_count", 64'(fifo_count), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        check("pp_head", 64'(cmd_jdo), 64'(d[1]));

        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("q3", 64'(fifo_count), 64'd3);
        tick();
        cmd_ready = 1'b1;
        reset     = 1'b1;
        vs_udr    = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("rst_mid_valid", 64'(cmd_valid), 64'd0);
        check("rst_mid_count", 64'(fifo_count), 64'd0);
        check("rst_mid_pulse", 64'({take_action, take_no_action}), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("held_no_cmd", 64'(fifo_count), 64'd0);
        vs_udr = 1'b0;
        tick(3);
        check("fall_no_cmd", 64'(cmd_valid), 64'd0);
        udr_pulse(38'h0000000777);
        check("rearm_valid", 64'(cmd_valid), 64'd1);
        check("rearm_jdo", 64'(cmd_jdo), 64'h777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
